// File: rtl/prog_loader_pkg.sv
// Shared constants for the program loader: defaults, the HLT padding byte
// and the sequencer state encoding.
package prog_loader_pkg;

  localparam int DEPTH_DEF   = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int TIMEOUT_DEF = 20000;

  localparam logic [7:0] HLT_BYTE = 8'h00;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_FILL   = 3'd2;
  localparam state_t ST_RUN    = 3'd3;
  localparam state_t ST_HALTED = 3'd4;
  localparam state_t ST_ERROR  = 3'd5;

endpackage

// File: rtl/prog_loader_ctrl_cnt.sv
// Clearable up-counter that stops at TERM and flags it. Used both as the
// inter-byte timeout counter and as the saturating RUN cycle counter.
module loader_timeout_cnt #(
  parameter int          W    = 16,
  parameter int unsigned TERM = 65535
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_term
);

  localparam logic [W-1:0] TERM_V = W'(TERM);

  logic [W-1:0] r_count;

  assign o_count = r_count;
  assign o_term  = (r_count == TERM_V);

  // clear wins over enable; the count holds once it reaches TERM
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_term) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/prog_loader_ctrl.sv
// Program-load / run sequencer: streams UART bytes into instruction memory,
// pads the remainder with HLT, then releases the core and watches for HLT.
//
//   state  | meaning
//   IDLE   | core held in reset, waiting for load_req
//   LOAD   | accepting bytes into imem[byte_count]
//   FILL   | writing HLT from byte_count to DEPTH-1
//   RUN    | core running (reset pulsed for the first cycle)
//   HALTED | core stopped on HLT, state kept observable
//   ERROR  | framing error or inter-byte timeout, waits for clear_err
module prog_loader_ctrl
  import prog_loader_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load_req,
  input  logic              i_clear_err,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_fe,
  input  logic              i_cpu_halted,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [7:0]        o_imem_wdata,
  output logic              o_cpu_rst,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_error,
  output logic              o_overflow,
  output logic [ADDR_W:0]   o_byte_count,
  output logic [15:0]       o_run_cycles
);

  localparam int              TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_byte_count;
  logic [ADDR_W:0]   r_fill_ptr;
  logic [ADDR_W:0]   w_bc_nxt;
  logic              r_overflow;
  logic              r_run_first;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;

  logic              w_fe;
  logic              w_accept;
  logic              w_discard;
  logic              w_enter_load;
  logic              w_enter_run;
  logic [TO_W-1:0]   w_to_count;
  logic              w_to_term;
  logic              w_to_hit;
  logic              w_run_sat;

  assign w_fe         = (r_state == ST_LOAD) && i_rx_valid && i_rx_fe;
  assign w_accept     = (r_state == ST_LOAD) && i_rx_valid && !i_rx_fe &&
                        (r_byte_count != DEPTH_CNT);
  assign w_discard    = (r_state == ST_LOAD) && i_rx_valid && !i_rx_fe &&
                        (r_byte_count == DEPTH_CNT);
  assign w_bc_nxt     = w_accept ? r_byte_count + (ADDR_W + 1)'(1) : r_byte_count;
  assign w_enter_load = (r_state != ST_LOAD) && (w_state_nxt == ST_LOAD);
  assign w_enter_run  = (r_state != ST_RUN) && (w_state_nxt == ST_RUN);
  // ERROR is entered on the edge where the idle count would reach TIMEOUT
  assign w_to_hit     = (w_to_count == TO_W'(TIMEOUT - 1)) && (r_byte_count != '0);

  loader_timeout_cnt #(
    .W    (TO_W),
    .TERM (TIMEOUT)
  ) u_timeout (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_enter_load || w_accept),
    .i_en    ((r_state == ST_LOAD) && (r_byte_count != '0) && !w_to_term),
    .o_count (w_to_count),
    .o_term  (w_to_term)
  );

  loader_timeout_cnt #(
    .W    (16),
    .TERM (16'hFFFF)
  ) u_run_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_enter_run),
    .i_en    ((r_state == ST_RUN) && !w_run_sat),
    .o_count (o_run_cycles),
    .o_term  (w_run_sat)
  );

  // next-state decode; framing error beats timeout beats load_req fall
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_load_req) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_fe) begin
          w_state_nxt = ST_ERROR;
        end else if (w_to_hit && !w_accept) begin
          w_state_nxt = ST_ERROR;
        end else if (!i_load_req) begin
          if (w_bc_nxt == '0)                  w_state_nxt = ST_IDLE;
          else if (r_byte_count == DEPTH_CNT)  w_state_nxt = ST_RUN;
          else                                 w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        if (r_fill_ptr == DEPTH_CNT) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (i_load_req)                         w_state_nxt = ST_LOAD;
        else if (i_cpu_halted && !r_run_first)  w_state_nxt = ST_HALTED;
      end
      ST_HALTED: begin
        if (i_load_req) w_state_nxt = ST_LOAD;
      end
      ST_ERROR: begin
        if (i_clear_err) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // state, byte/fill pointers and the registered memory write port
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_byte_count <= '0;
      r_fill_ptr   <= '0;
      r_overflow   <= 1'b0;
      r_run_first  <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_run_first <= w_enter_run;
      r_we        <= 1'b0;
      if (w_enter_load) begin
        r_byte_count <= '0;
        r_overflow   <= 1'b0;
      end else begin
        if (w_accept) begin
          r_we         <= 1'b1;
          r_addr       <= r_byte_count[ADDR_W-1:0];
          r_wdata      <= i_rx_data;
          r_byte_count <= w_bc_nxt;
        end
        if (w_discard) r_overflow <= 1'b1;
      end
      if ((r_state == ST_LOAD) && (w_state_nxt == ST_FILL)) begin
        r_fill_ptr <= w_bc_nxt;
      end else if ((r_state == ST_FILL) && (r_fill_ptr != DEPTH_CNT)) begin
        r_we       <= 1'b1;
        r_addr     <= r_fill_ptr[ADDR_W-1:0];
        r_wdata    <= HLT_BYTE;
        r_fill_ptr <= r_fill_ptr + (ADDR_W + 1)'(1);
      end
    end
  end

  // core control follows the state; reset is released after the first RUN cycle
  always_comb begin
    o_cpu_rst  = 1'b1;
    o_cpu_hold = 1'b1;
    case (r_state)
      ST_RUN: begin
        o_cpu_rst  = r_run_first;
        o_cpu_hold = 1'b0;
      end
      ST_HALTED: o_cpu_rst = 1'b0;
      default: ;
    endcase
  end

  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;
  assign o_done       = (r_state == ST_HALTED);
  assign o_error      = (r_state == ST_ERROR);
  assign o_overflow   = r_overflow;
  assign o_byte_count = r_byte_count;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Bench for prog_loader_ctrl: table of load scenarios plus hand-written
// timeout, halt and reset-during-fill sequences; memory writes are checked
// against a queue of expected (addr, data) pairs.
module tb_prog_loader_ctrl;

  localparam int TIMEOUT = 20000;

  logic        clk;
  logic        i_reset;
  logic        i_load_req;
  logic        i_clear_err;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        i_rx_fe;
  logic        i_cpu_halted;
  logic        o_imem_we;
  logic [4:0]  o_imem_addr;
  logic [7:0]  o_imem_wdata;
  logic        o_cpu_rst;
  logic        o_cpu_hold;
  logic        o_done;
  logic        o_error;
  logic        o_overflow;
  logic [5:0]  o_byte_count;
  logic [15:0] o_run_cycles;

  prog_loader_ctrl #(
    .DEPTH   (32),
    .ADDR_W  (5),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_load_req   (i_load_req),
    .i_clear_err  (i_clear_err),
    .i_rx_valid   (i_rx_valid),
    .i_rx_data    (i_rx_data),
    .i_rx_fe      (i_rx_fe),
    .i_cpu_halted (i_cpu_halted),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_cpu_rst    (o_cpu_rst),
    .o_cpu_hold   (o_cpu_hold),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_overflow   (o_overflow),
    .o_byte_count (o_byte_count),
    .o_run_cycles (o_run_cycles)
  );

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    int         nbytes;
    int         fe_at;
    bit         fall_with_last;
    logic [7:0] base;
    int         exp_bc;
    bit         exp_ovf;
    bit         exp_err;
    int         exp_writes;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[8];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_we_cyc = 0;
  int   n_writes = 0;
  bit   ok;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // write-port scoreboard
  always @(negedge clk) begin
    wr_t e;
    if (o_imem_we === 1'b1) begin
      n_writes++;
      last_we_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL imem_write: unexpected write addr=%0d data=%02h", o_imem_addr, o_imem_wdata);
      end else begin
        e = sb.pop_front();
        if ({o_imem_addr, o_imem_wdata} !== {e.addr, e.data}) begin
          errors++;
          $display("FAIL imem_write: got addr=%0d data=%02h expected addr=%0d data=%02h",
                   o_imem_addr, o_imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic do_reset();
    i_reset      = 1'b1;
    i_load_req   = 1'b0;
    i_clear_err  = 1'b0;
    i_rx_valid   = 1'b0;
    i_rx_data    = 8'h00;
    i_rx_fe      = 1'b0;
    i_cpu_halted = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sb.delete();
    i_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_run(output bit found);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (o_cpu_hold === 1'b0) begin
        found = 1'b1;
        return;
      end
    end
  endtask

  // sends n bytes back to back, queues expected writes incl. HLT padding, drops load_req
  task automatic load_bytes(input int n, input logic [7:0] base);
    i_load_req = 1'b1;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      i_rx_data  = base + 8'(i);
      i_rx_valid = 1'b1;
      sb.push_back('{addr: 5'(i), data: base + 8'(i)});
      @(negedge clk);
      i_rx_valid = 1'b0;
    end
    for (int a = n; a < 32; a++) sb.push_back('{addr: 5'(a), data: 8'h00});
    i_load_req = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   pushed;
    bit   gap_chk;

    vecs[0] = '{3,  -1, 1'b0, 8'hA1, 3,  1'b0, 1'b0, 32};
    vecs[1] = '{33, -1, 1'b0, 8'h10, 32, 1'b1, 1'b0, 32};
    vecs[2] = '{32, -1, 1'b1, 8'h55, 32, 1'b0, 1'b0, 32};
    vecs[3] = '{31, -1, 1'b0, 8'h07, 31, 1'b0, 1'b0, 32};
    vecs[4] = '{5,   2, 1'b0, 8'h30, 2,  1'b0, 1'b1, 2};
    vecs[5] = '{0,  -1, 1'b0, 8'h00, 0,  1'b0, 1'b0, 0};
    vecs[6] = '{4,  -1, 1'b1, 8'hF0, 4,  1'b0, 1'b0, 32};
    vecs[7] = '{1,  -1, 1'b0, 8'hEE, 1,  1'b0, 1'b0, 32};

    do_reset();
    chk("rst_imem_we",    o_imem_we,    0);
    chk("rst_imem_addr",  o_imem_addr,  0);
    chk("rst_imem_wdata", o_imem_wdata, 0);
    chk("rst_cpu_rst",    o_cpu_rst,    1);
    chk("rst_cpu_hold",   o_cpu_hold,   1);
    chk("rst_done",       o_done,       0);
    chk("rst_error",      o_error,      0);
    chk("rst_overflow",   o_overflow,   0);
    chk("rst_byte_count", o_byte_count, 0);
    chk("rst_run_cycles", o_run_cycles, 0);

    for (int vi = 0; vi < 8; vi++) begin
      v = vecs[vi];
      do_reset();
      n_writes   = 0;
      pushed     = 0;
      i_load_req = 1'b1;
      @(negedge clk);
      for (int i = 0; i < v.nbytes; i++) begin
        if (v.fe_at >= 0 && i > v.fe_at) break;
        i_rx_data  = v.base + 8'(i * 33);
        i_rx_valid = 1'b1;
        i_rx_fe    = (i == v.fe_at);
        if (i != v.fe_at && pushed < 32) begin
          sb.push_back('{addr: 5'(pushed), data: i_rx_data});
          pushed++;
        end
        if (v.fall_with_last && i == v.nbytes - 1) begin
          for (int a = pushed; a < 32; a++) sb.push_back('{addr: 5'(a), data: 8'h00});
          i_load_req = 1'b0;
        end
        @(negedge clk);
        i_rx_valid = 1'b0;
        i_rx_fe    = 1'b0;
        if (i != v.nbytes - 1) repeat (i % 3) @(negedge clk);
      end

      if (v.exp_err) begin
        chk($sformatf("v%0d_error_set", vi), o_error, 1);
        chk($sformatf("v%0d_byte_count", vi), o_byte_count, v.exp_bc);
        @(negedge clk);
        chk($sformatf("v%0d_error_ignores_load_req", vi), o_error, 1);
        i_load_req  = 1'b0;
        i_clear_err = 1'b1;
        @(negedge clk);
        i_clear_err = 1'b0;
        chk($sformatf("v%0d_error_cleared", vi), o_error, 0);
        chk($sformatf("v%0d_idle_cpu_rst", vi), o_cpu_rst, 1);
        chk($sformatf("v%0d_idle_cpu_hold", vi), o_cpu_hold, 1);
        chk($sformatf("v%0d_writes", vi), n_writes, v.exp_writes);
      end else if (v.nbytes == 0) begin
        i_load_req = 1'b0;
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_byte_count", vi), o_byte_count, 0);
        chk($sformatf("v%0d_idle_cpu_hold", vi), o_cpu_hold, 1);
        chk($sformatf("v%0d_idle_cpu_rst", vi), o_cpu_rst, 1);
        chk($sformatf("v%0d_writes", vi), n_writes, v.exp_writes);
      end else begin
        gap_chk = v.fall_with_last || (pushed < 32);
        if (!v.fall_with_last) begin
          for (int a = pushed; a < 32; a++) sb.push_back('{addr: 5'(a), data: 8'h00});
          i_load_req = 1'b0;
        end
        wait_run(ok);
        chk($sformatf("v%0d_run_reached", vi), ok, 1);
        chk($sformatf("v%0d_run_first_cpu_rst", vi), o_cpu_rst, 1);
        if (gap_chk) chk($sformatf("v%0d_run_after_last_write", vi), cyc - last_we_cyc, 1);
        @(negedge clk);
        chk($sformatf("v%0d_run_cpu_rst_low", vi), o_cpu_rst, 0);
        chk($sformatf("v%0d_run_cpu_hold", vi), o_cpu_hold, 0);
        chk($sformatf("v%0d_byte_count", vi), o_byte_count, v.exp_bc);
        chk($sformatf("v%0d_overflow", vi), o_overflow, v.exp_ovf);
        chk($sformatf("v%0d_error", vi), o_error, 0);
        chk($sformatf("v%0d_writes", vi), n_writes, v.exp_writes);
        chk($sformatf("v%0d_sb_drained", vi), sb.size(), 0);
      end
    end

    // inter-byte timeout, restarted by a second byte
    do_reset();
    i_load_req = 1'b1;
    @(negedge clk);
    i_rx_data  = 8'h5A;
    i_rx_valid = 1'b1;
    sb.push_back('{addr: 5'd0, data: 8'h5A});
    @(negedge clk);
    i_rx_valid = 1'b0;
    repeat (15000) @(negedge clk);
    chk("timeout_not_yet_first", o_error, 0);
    i_rx_data  = 8'hA5;
    i_rx_valid = 1'b1;
    sb.push_back('{addr: 5'd1, data: 8'hA5});
    @(negedge clk);
    i_rx_valid = 1'b0;
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("timeout_edge_minus_one", o_error, 0);
    @(negedge clk);
    chk("timeout_error", o_error, 1);
    chk("timeout_byte_count", o_byte_count, 2);

    // halt detection, first-cycle halt ignored, clear_err outside ERROR
    do_reset();
    load_bytes(2, 8'h11);
    wait_run(ok);
    chk("halt_run_reached", ok, 1);
    i_cpu_halted = 1'b1;
    @(negedge clk);
    i_cpu_halted = 1'b0;
    chk("halt_first_cycle_ignored", o_cpu_hold, 0);
    repeat (7) @(negedge clk);
    chk("halt_run_cycles_mid", o_run_cycles, 8);
    @(negedge clk);
    i_cpu_halted = 1'b1;
    @(negedge clk);
    i_cpu_halted = 1'b0;
    chk("halt_done", o_done, 1);
    chk("halt_cpu_hold", o_cpu_hold, 1);
    chk("halt_cpu_rst", o_cpu_rst, 0);
    chk("halt_run_cycles", o_run_cycles, 10);
    i_clear_err = 1'b1;
    @(negedge clk);
    i_clear_err = 1'b0;
    chk("halt_clear_err_no_effect", o_done, 1);
    chk("halt_run_cycles_hold", o_run_cycles, 10);
    i_load_req = 1'b1;
    @(negedge clk);
    chk("reload_done_low", o_done, 0);
    chk("reload_cpu_rst", o_cpu_rst, 1);
    chk("reload_byte_count", o_byte_count, 0);
    i_load_req = 1'b0;
    @(negedge clk);

    // asynchronous reset in the middle of FILL
    do_reset();
    load_bytes(3, 8'hC0);
    repeat (6) @(negedge clk);
    chk("fill_we_before_reset", o_imem_we, 1);
    chk("fill_addr_before_reset", o_imem_addr, 7);
    #2;
    i_reset = 1'b1;
    #1;
    chk("arst_imem_we", o_imem_we, 0);
    chk("arst_imem_addr", o_imem_addr, 0);
    chk("arst_byte_count", o_byte_count, 0);
    chk("arst_cpu_rst", o_cpu_rst, 1);
    chk("arst_cpu_hold", o_cpu_hold, 1);
    chk("arst_done", o_done, 0);
    sb.delete();
    @(negedge clk);
    i_reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_arst_idle_hold", o_cpu_hold, 1);
    chk("post_arst_idle_error", o_error, 0);
    chk("post_arst_no_write", o_imem_we, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
